// File: rtl/arr_scan_ctrl.sv
// Sweep sequencer for the arr array: loads an LFSR-derived pattern into each
// selected instance, waits a settle window, then requests a compare and tallies failures.
module arr_scan_ctrl #(
  parameter int INSTANCES   = 255,
  parameter int IDX_W       = 8,
  parameter int DATA_W      = 255,
  parameter int SETTLE      = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int ERR_W       = 16
) (
  input  logic              scan_ctrl_clk_ip,
  input  logic              scan_ctrl_rst_ip,
  input  logic              scan_ctrl_start_ip,
  input  logic              scan_ctrl_abort_ip,
  input  logic [IDX_W-1:0]  scan_ctrl_first_ip,
  input  logic [IDX_W-1:0]  scan_ctrl_last_ip,
  input  logic [31:0]       scan_ctrl_seed_ip,
  input  logic              scan_ctrl_inject_ip,
  output logic [IDX_W-1:0]  scan_ctrl_sel_op,
  output logic              scan_ctrl_wr_op,
  output logic [DATA_W-1:0] scan_ctrl_sig0_op,
  output logic [DATA_W-1:0] scan_ctrl_sig1_op,
  output logic              scan_ctrl_chk_op,
  input  logic              scan_ctrl_chk_ack_ip,
  input  logic              scan_ctrl_chk_err_ip,
  output logic              scan_ctrl_busy_op,
  output logic              scan_ctrl_done_op,
  output logic              scan_ctrl_aborted_op,
  output logic              scan_ctrl_timeout_op,
  output logic [ERR_W-1:0]  scan_ctrl_err_cnt_op
);

  localparam logic [31:0]      POLY    = 32'h80200003;
  localparam int               CNT_MAX = (SETTLE > ACK_TIMEOUT) ? SETTLE : ACK_TIMEOUT;
  localparam int               CNT_W   = $clog2(CNT_MAX + 1);
  localparam int               REP     = (DATA_W + 31) / 32;
  localparam logic [IDX_W:0]   MAX_IDX = (IDX_W + 1)'(INSTANCES);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_sel, r_last;
  logic [31:0]       r_lfsr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sig0, r_sig1;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              r_aborted, r_timeout;

  logic [IDX_W-1:0]  w_first_c, w_last_c, w_load_sel;
  logic [31:0]       w_seed, w_lfsr_next, w_load_lfsr;
  logic [DATA_W-1:0] w_pat;
  logic              w_busy, w_abort, w_tmo, w_fail, w_enter_load;

  function automatic logic [IDX_W-1:0] clamp(input logic [IDX_W-1:0] x);
    if (x == '0) return IDX_W'(1);
    else if ({1'b0, x} > MAX_IDX) return MAX_IDX[IDX_W-1:0];
    else return x;
  endfunction

  // LFSR word repeated across the bus, bits at and above sel forced to zero
  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] lfsr,
                                                input logic [IDX_W-1:0] sel);
    logic [REP*32-1:0] rep;
    rep = {REP{lfsr}};
    return rep[DATA_W-1:0] & ~({DATA_W{1'b1}} << sel);
  endfunction

  assign w_first_c    = clamp(scan_ctrl_first_ip);
  assign w_last_c     = clamp(scan_ctrl_last_ip);
  assign w_seed       = (scan_ctrl_seed_ip == 32'd0) ? 32'd1 : scan_ctrl_seed_ip;
  assign w_lfsr_next  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? POLY : 32'd0);
  assign w_busy       = r_state inside {S_LOAD, S_SETTLE, S_CHECK, S_NEXT};
  assign w_abort      = w_busy & scan_ctrl_abort_ip;
  assign w_tmo        = (r_state == S_CHECK) && !scan_ctrl_chk_ack_ip &&
                        (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign w_fail       = (r_state == S_CHECK) && !w_abort &&
                        ((scan_ctrl_chk_ack_ip && scan_ctrl_chk_err_ip) || w_tmo);
  assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);
  assign w_load_sel   = (r_state == S_IDLE) ? w_first_c : r_sel + 1'b1;
  assign w_load_lfsr  = (r_state == S_IDLE) ? w_seed : w_lfsr_next;
  assign w_pat        = pattern(w_load_lfsr, w_load_sel);

  always_ff @(posedge scan_ctrl_clk_ip or posedge scan_ctrl_rst_ip) begin
    if (scan_ctrl_rst_ip) r_state <= S_IDLE;
    else                  r_state <= w_next;
  end

  // Abort overrides every transition out of a busy state
  always_comb begin
    w_next            = r_state;
    scan_ctrl_wr_op   = 1'b0;
    scan_ctrl_chk_op  = 1'b0;
    scan_ctrl_busy_op = 1'b0;
    scan_ctrl_done_op = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (scan_ctrl_start_ip) w_next = (w_first_c > w_last_c) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        scan_ctrl_wr_op   = 1'b1;
        scan_ctrl_busy_op = 1'b1;
        w_next            = S_SETTLE;
      end
      S_SETTLE: begin
        scan_ctrl_busy_op = 1'b1;
        if (r_cnt == CNT_W'(SETTLE - 1)) w_next = S_CHECK;
      end
      S_CHECK: begin
        scan_ctrl_chk_op  = 1'b1;
        scan_ctrl_busy_op = 1'b1;
        if (scan_ctrl_chk_ack_ip || w_tmo) w_next = S_NEXT;
      end
      S_NEXT: begin
        scan_ctrl_busy_op = 1'b1;
        w_next            = (r_sel == r_last) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        scan_ctrl_busy_op = 1'b1;
        scan_ctrl_done_op = 1'b1;
        w_next            = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_DONE;
  end

  always_ff @(posedge scan_ctrl_clk_ip or posedge scan_ctrl_rst_ip) begin
    if (scan_ctrl_rst_ip) begin
      r_sel     <= '0;
      r_last    <= '0;
      r_lfsr    <= 32'd1;
      r_cnt     <= '0;
      r_sig0    <= '0;
      r_sig1    <= '0;
      r_err_cnt <= '0;
      r_aborted <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != w_next)                               r_cnt <= '0;
      else if (r_state == S_SETTLE || r_state == S_CHECK)  r_cnt <= r_cnt + 1'b1;

      if (r_state == S_IDLE && scan_ctrl_start_ip) begin
        r_err_cnt <= '0;
        r_aborted <= 1'b0;
        r_timeout <= 1'b0;
        r_lfsr    <= w_seed;
        r_sel     <= w_first_c;
        r_last    <= w_last_c;
      end else begin
        if (r_state == S_NEXT) r_lfsr <= w_lfsr_next;
        if (r_state == S_NEXT && w_next == S_LOAD) r_sel <= w_load_sel;
        if (w_fail && r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 1'b1;
        if (w_tmo && !w_abort) r_timeout <= 1'b1;
        if (w_abort) r_aborted <= 1'b1;
      end

      // Pattern is captured on entry to LOAD so it stays stable until the next one
      if (w_enter_load) begin
        r_sig0 <= w_pat;
        r_sig1 <= w_pat ^ {{(DATA_W - 1){1'b0}}, scan_ctrl_inject_ip};
      end
    end
  end

  assign scan_ctrl_sel_op     = r_sel;
  assign scan_ctrl_sig0_op    = r_sig0;
  assign scan_ctrl_sig1_op    = r_sig1;
  assign scan_ctrl_aborted_op = r_aborted;
  assign scan_ctrl_timeout_op = r_timeout;
  assign scan_ctrl_err_cnt_op = r_err_cnt;

endmodule

// File: tb/tb_arr_scan_ctrl.sv
// Table-driven bench for arr_scan_ctrl: each sweep pushes its expected writes into
// a scoreboard that is drained on every wr_op, then latency and status are compared.
module tb_arr_scan_ctrl;

  localparam int IDX_W  = 8;
  localparam int DATA_W = 255;
  localparam int ERR_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0, abort = 1'b0, inject = 1'b0;
  logic [IDX_W-1:0]  firstIn = '0, lastIn = '0;
  logic [31:0]       seedIn = '0;
  logic              ack = 1'b0, chkErr = 1'b0;
  logic [IDX_W-1:0]  selOut;
  logic              wrOut, chkOut, busyOut, doneOut, abortedOut, timeoutOut;
  logic [DATA_W-1:0] sig0Out, sig1Out;
  logic [ERR_W-1:0]  errCnt;

  int checks = 0;
  int passes = 0;

  int   ackDelay  = 0;
  logic ackErrVal = 1'b0;
  int   abortInst = 0;
  logic noise     = 1'b0;
  int   chkWait   = 0;

  typedef struct {
    int first, last;
    logic [31:0] seed;
    logic inject;
    int ackDelay;
    logic ackErrVal;
    int abortInst;
    logic noise, midStart;
    int expWrites, expErr;
    logic expTimeout, expAborted;
    int expLatency, expChk;
  } vec_t;

  typedef struct {
    logic [IDX_W-1:0]  sel;
    logic [DATA_W-1:0] sig0, sig1;
  } wr_t;

  vec_t vecs[7];
  wr_t  sbq[$];

  arr_scan_ctrl dut (
    .scan_ctrl_clk_ip     (clock),
    .scan_ctrl_rst_ip     (reset),
    .scan_ctrl_start_ip   (start),
    .scan_ctrl_abort_ip   (abort),
    .scan_ctrl_first_ip   (firstIn),
    .scan_ctrl_last_ip    (lastIn),
    .scan_ctrl_seed_ip    (seedIn),
    .scan_ctrl_inject_ip  (inject),
    .scan_ctrl_sel_op     (selOut),
    .scan_ctrl_wr_op      (wrOut),
    .scan_ctrl_sig0_op    (sig0Out),
    .scan_ctrl_sig1_op    (sig1Out),
    .scan_ctrl_chk_op     (chkOut),
    .scan_ctrl_chk_ack_ip (ack),
    .scan_ctrl_chk_err_ip (chkErr),
    .scan_ctrl_busy_op    (busyOut),
    .scan_ctrl_done_op    (doneOut),
    .scan_ctrl_aborted_op (abortedOut),
    .scan_ctrl_timeout_op (timeoutOut),
    .scan_ctrl_err_cnt_op (errCnt)
  );

  always #5 clock = ~clock;

  // Compare-side responder; noise drives ack/err while no compare is pending
  always @(negedge clock) begin
    ack    = 1'b0;
    chkErr = 1'b0;
    abort  = 1'b0;
    if (chkOut) begin
      if (abortInst != 0 && int'(selOut) == abortInst && chkWait == 0) abort = 1'b1;
      if (ackDelay >= 0 && chkWait == ackDelay) begin
        ack    = 1'b1;
        chkErr = ackErrVal;
      end
      chkWait++;
    end else begin
      chkWait = 0;
      if (noise) begin
        ack    = 1'b1;
        chkErr = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    else passes++;
  endtask

  function automatic int clampM(input int x);
    if (x <= 0) return 1;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic logic [31:0] lfsrStep(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] patM(input logic [31:0] l, input int s);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i < s) p[i[7:0]] = l[i[4:0]];
    return p;
  endfunction

  task automatic pushExpected(input vec_t v);
    int lo, hi;
    logic [31:0] l;
    lo = clampM(v.first);
    hi = clampM(v.last);
    l  = (v.seed == 32'd0) ? 32'd1 : v.seed;
    if (v.abortInst != 0 && v.abortInst < hi) hi = v.abortInst;
    for (int s = lo; s <= hi; s++) begin
      wr_t w;
      w.sel  = s[7:0];
      w.sig0 = patM(l, s);
      w.sig1 = w.sig0 ^ {{(DATA_W - 1){1'b0}}, v.inject};
      sbq.push_back(w);
      l = lfsrStep(l);
    end
  endtask

  task automatic popCompare();
    wr_t w;
    checkOutput("sb_nonempty", 256'(sbq.size() != 0), 256'(1));
    if (sbq.size() != 0) begin
      w = sbq.pop_front();
      checkOutput("wr_sel", 256'(selOut), 256'(w.sel));
      checkOutput("wr_sig0", 256'(sig0Out), 256'(w.sig0));
      checkOutput("wr_sig1", 256'(sig1Out), 256'(w.sig1));
    end
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_sel"}, 256'(selOut), 256'(0));
    checkOutput({tag, "_wr"}, 256'(wrOut), 256'(0));
    checkOutput({tag, "_sig0"}, 256'(sig0Out), 256'(0));
    checkOutput({tag, "_sig1"}, 256'(sig1Out), 256'(0));
    checkOutput({tag, "_chk"}, 256'(chkOut), 256'(0));
    checkOutput({tag, "_busy"}, 256'(busyOut), 256'(0));
    checkOutput({tag, "_done"}, 256'(doneOut), 256'(0));
    checkOutput({tag, "_aborted"}, 256'(abortedOut), 256'(0));
    checkOutput({tag, "_timeout"}, 256'(timeoutOut), 256'(0));
    checkOutput({tag, "_err"}, 256'(errCnt), 256'(0));
  endtask

  task automatic setup(input vec_t v);
    ackDelay  = v.ackDelay;
    ackErrVal = v.ackErrVal;
    abortInst = v.abortInst;
    noise     = v.noise;
    firstIn   = v.first[7:0];
    lastIn    = v.last[7:0];
    seedIn    = v.seed;
    inject    = v.inject;
    pushExpected(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc = 0, latency = -1, wrSeen = 0, chkSeen = 0, extra = 0;
    setup(v);
    start = 1'b1;
    while (cyc < 2000 && latency < 0) begin
      @(negedge clock);
      cyc++;
      start = v.midStart && (cyc == 5);
      if (wrOut) begin
        wrSeen++;
        popCompare();
      end
      if (chkOut) chkSeen++;
      if (doneOut) latency = cyc;
    end
    start = 1'b0;
    checkOutput("latency", 256'(latency), 256'(v.expLatency));
    checkOutput("err_cnt", 256'(errCnt), 256'(v.expErr));
    checkOutput("timeout", 256'(timeoutOut), 256'(v.expTimeout));
    checkOutput("aborted", 256'(abortedOut), 256'(v.expAborted));
    @(negedge clock);
    checkOutput("busy_after", 256'(busyOut), 256'(0));
    checkOutput("done_pulse_width", 256'(doneOut), 256'(0));
    repeat (3) begin
      @(negedge clock);
      if (wrOut || doneOut || chkOut) extra++;
    end
    checkOutput("quiet_after", 256'(extra), 256'(0));
    checkOutput("wr_count", 256'(wrSeen), 256'(v.expWrites));
    checkOutput("chk_cycles", 256'(chkSeen), 256'(v.expChk));
    checkOutput("sb_left", 256'(sbq.size()), 256'(0));
    sbq.delete();
  endtask

  initial begin
    vec_t rv;
    int extra = 0;
    // first last seed inj dly err abrt noise mid | writes err tmo abt lat chk
    vecs[0] = '{1,   4,   32'd1,        1'b0,  1, 1'b0, 0, 1'b1, 1'b0,   4, 0, 1'b0, 1'b0,   25,   8};
    vecs[1] = '{10,  12,  32'h0000ACE1, 1'b1,  1, 1'b1, 0, 1'b1, 1'b0,   3, 3, 1'b0, 1'b0,   19,   6};
    vecs[2] = '{5,   5,   32'd0,        1'b0, -1, 1'b0, 0, 1'b0, 1'b0,   1, 1, 1'b1, 1'b0,   21,  16};
    vecs[3] = '{1,   255, 32'h00C0FFEE, 1'b0,  0, 1'b1, 3, 1'b0, 1'b0,   3, 2, 1'b0, 1'b1,   15,   3};
    vecs[4] = '{7,   3,   32'd9,        1'b0,  1, 1'b0, 0, 1'b0, 1'b0,   0, 0, 1'b0, 1'b0,    1,   0};
    vecs[5] = '{0,   255, 32'hDEADBEEF, 1'b0,  0, 1'b0, 0, 1'b1, 1'b0, 255, 0, 1'b0, 1'b0, 1276, 255};
    vecs[6] = '{200, 200, 32'h12345678, 1'b1,  3, 1'b1, 0, 1'b0, 1'b1,   1, 1, 1'b0, 1'b0,    9,   4};

    inject = 1'b1;
    repeat (3) @(negedge clock);
    resetChecks("por");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Reset while the second instance is settling, after one failure was logged
    rv           = vecs[0];
    rv.ackDelay  = 0;
    rv.ackErrVal = 1'b1;
    rv.noise     = 1'b0;
    setup(rv);
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (wrOut) popCompare();
    end
    checkOutput("pre_reset_err", 256'(errCnt), 256'(1));
    checkOutput("pre_reset_busy", 256'(busyOut), 256'(1));
    reset = 1'b1;
    #1;
    resetChecks("midreset");
    repeat (4) begin
      @(negedge clock);
      if (doneOut || busyOut) extra++;
    end
    checkOutput("reset_no_done", 256'(extra), 256'(0));
    reset = 1'b0;
    sbq.delete();
    @(negedge clock);
    applyStimulus(vecs[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
